pipeline_arith3: RTL and testbench
==================================

// Module: pipeline_arith3
// PURPOSE
//  Three-stage pipelined arithmetic datapath computing F = ((A+B) + (C-D)) * D.
//  Accepts one operand set per clock and produces one result per clock after a
//  fixed 3-cycle latency. Used as a throughput-oriented compute kernel. All
//  operands and the result are unsigned N-bit values.
// PARAMETERS
//  N  10  operand, intermediate and result width in bits
// PORTS
//  clk        in   1  clock; all state updates on rising edge
//  rst_n      in   1  asynchronous active-low reset
//  in_valid   in   1  operand set on A..D is valid this cycle
//  A          in   N  addend 1
//  B          in   N  addend 2
//  C          in   N  minuend
//  D          in   N  subtrahend and final multiplier
//  out_valid  out  1  F holds a result for a valid operand set
//  F          out  N  result, registered
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-low.
//  - Reset: while rst_n=0 all pipeline registers, F and out_valid are 0,
//    asynchronously and independent of clk. First capture is on the first
//    rising edge after rst_n deasserts.
//  - Stage 1 (edge k): x1 <= A+B; x2 <= C-D; d1 <= D; v1 <= in_valid.
//  - Stage 2 (edge k+1): x3 <= x1+x2; d2 <= d1; v2 <= v1.
//  - Stage 3 (edge k+2): F <= x3*d2 (low N bits); out_valid <= v2.
//  - Latency: inputs sampled at edge k appear on F after edge k+2, i.e. 3
//    register stages. Throughput 1 result/cycle, no stalls, no backpressure.
//  - Data stages advance every cycle regardless of in_valid. in_valid only
//    tags the data in the pipeline.
//  - Width: every intermediate is N bits. All add, subtract and multiply
//    results wrap modulo 2^N with no carry, borrow or overflow flag.
//    C<D wraps: C-D = 2^N + C - D.
//  - Reset mid-operation clears all in-flight results. out_valid stays 0
//    until 3 edges after valid data re-enters.
// TESTING
//  - Reset: rst_n=0 mid-stream -> F=0 and out_valid=0 immediately, no clk
//    edge needed. After release, the first valid result appears 3 edges later.
//  - Streaming, N=10, one set per cycle (A,B,C,D):
//    (10,12,6,3) (10,10,5,3) (20,11,1,4) (15,10,8,2) (8,15,5,0) (10,20,5,3)
//    (10,10,30,1) (30,1,2,4) -> F = 75,66,112,62,0,96,49,116 on consecutive
//    cycles, starting 3 edges after the first set is sampled.
//  - Wrap: A=1023,B=1,C=0,D=1 -> F=(0+1023)*1=1023.
//    A=0,B=0,C=2,D=3 -> x2=1023, x3=1023, F=1023*3 mod 1024=1021.
//  - Multiply overflow: A=500,B=0,C=5,D=5 -> F=2500 mod 1024=452.
//  - Valid tagging: pulse in_valid for 1 cycle within idle cycles -> out_valid
//    high for exactly 1 cycle, 3 edges later, aligned with the matching F.
//  - Zero multiplier: D=0 with any A,B,C -> F=0.

Source files
------------

// File: rtl/pipeline_arith3_if.sv
// Operand/result bundle for the three-stage arithmetic kernel.
// Master drives operands and in_valid; slave returns F and out_valid.
interface pipeline_arith3_if #(
  parameter int N = 10
);
  logic         in_valid;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] C;
  logic [N-1:0] D;
  logic         out_valid;
  logic [N-1:0] F;

  modport master (
    output in_valid, A, B, C, D,
    input  out_valid, F
  );

  modport slave (
    input  in_valid, A, B, C, D,
    output out_valid, F
  );
endinterface

// File: rtl/pipeline_arith3.sv
// Three-stage pipelined datapath: F = ((A+B) + (C-D)) * D mod 2^N.
// One operand set per clock, fixed 3-cycle latency, no stalls.
module pipeline_arith3 #(
  parameter int N = 10
) (
  input  logic clk,
  input  logic rst_n,
  pipeline_arith3_if.slave io
);

  typedef struct packed {
    logic         v;
    logic [N-1:0] x1;
    logic [N-1:0] x2;
    logic [N-1:0] d;
  } s1_t;

  typedef struct packed {
    logic         v;
    logic [N-1:0] x3;
    logic [N-1:0] d;
  } s2_t;

  typedef struct packed {
    logic         v;
    logic [N-1:0] f;
  } s3_t;

  s1_t s1_q;
  s2_t s2_q;
  s3_t s3_q;

  logic [N-1:0] sum_ab;
  logic [N-1:0] dif_cd;
  logic [N-1:0] sum_x;
  logic [N-1:0] prod;

  // All arithmetic is N bits wide and wraps silently.
  assign sum_ab = io.A + io.B;
  assign dif_cd = io.C - io.D;
  assign sum_x  = s1_q.x1 + s1_q.x2;
  assign prod   = s2_q.x3 * s2_q.d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else begin
      s1_q.v  <= io.in_valid;
      s1_q.x1 <= sum_ab;
      s1_q.x2 <= dif_cd;
      s1_q.d  <= io.D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_q <= '0;
    end else begin
      s2_q.v  <= s1_q.v;
      s2_q.x3 <= sum_x;
      s2_q.d  <= s1_q.d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_q <= '0;
    end else begin
      s3_q.v <= s2_q.v;
      s3_q.f <= prod;
    end
  end

  assign io.F         = s3_q.f;
  assign io.out_valid = s3_q.v;

endmodule

// File: tb/tb_pipeline_arith3.sv
// Bench for pipeline_arith3: table vectors, reset and tagging sequences.
// Expected results travel through a queue matching the 3-cycle latency.
module tb_pipeline_arith3;
  localparam int N = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pipeline_arith3_if #(.N(N)) bus ();

  pipeline_arith3 #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic [N-1:0] d;
    logic [N-1:0] f;
  } vec_t;

  typedef struct {
    logic         v;
    logic [N-1:0] f;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[12];

  int napplied = 0;
  int nmis = 0;

  task automatic chk(input string nm,
                     input logic [N-1:0] act,
                     input logic [N-1:0] req);
    napplied++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               nm, act, req, $time);
    end
  endtask

  function automatic logic [N-1:0] model(input int a, input int b,
                                         input int c, input int d);
    int s;
    s = (a + b + c - d + 1024) % 1024;
    return N'((s * d) % 1024);
  endfunction

  // One cycle: check what left the pipe, then drive the next set.
  task automatic step(input logic v,
                      input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [N-1:0] c, input logic [N-1:0] d,
                      input logic [N-1:0] f);
    exp_t e;
    @(negedge clk);
    if (sbq.size() >= 3) begin
      e = sbq.pop_front();
      chk("out_valid", N'(bus.out_valid), N'(e.v));
      if (e.v) chk("F", bus.F, e.f);
    end
    bus.in_valid = v;
    bus.A = a;
    bus.B = b;
    bus.C = c;
    bus.D = d;
    e.v = v;
    e.f = f;
    sbq.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, '0, '0);
  endtask

  task automatic release_reset();
    exp_t e;
    @(negedge clk);
    rst_n = 1'b1;
    sbq.delete();
    e.v = 1'b0;
    e.f = '0;
    repeat (3) sbq.push_back(e);
  endtask

  task automatic put(input int i, input int a, input int b,
                     input int c, input int d, input int f);
    tbl[i].a = N'(a);
    tbl[i].b = N'(b);
    tbl[i].c = N'(c);
    tbl[i].d = N'(d);
    tbl[i].f = N'(f);
  endtask

  initial begin
    put(0, 10, 12, 6, 3, 75);
    put(1, 10, 10, 5, 3, 66);
    put(2, 20, 11, 1, 4, 112);
    put(3, 15, 10, 8, 2, 62);
    put(4, 8, 15, 5, 0, 0);
    put(5, 10, 20, 5, 3, 96);
    put(6, 10, 10, 30, 1, 49);
    put(7, 30, 1, 2, 4, 116);
    put(8, 1023, 1, 0, 1, 1023);
    put(9, 0, 0, 2, 3, 1021);
    put(10, 500, 0, 5, 5, 452);
    put(11, 777, 123, 999, 0, 0);

    bus.in_valid = 1'b1;
    bus.A = 10'd5;
    bus.B = 10'd6;
    bus.C = 10'd7;
    bus.D = 10'd8;
    repeat (3) @(negedge clk);
    chk("reset F", bus.F, '0);
    chk("reset out_valid", N'(bus.out_valid), '0);
    bus.in_valid = 1'b0;
    release_reset();

    // Back-to-back stream of all table vectors.
    for (int i = 0; i < 12; i++)
      step(1'b1, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].f);
    repeat (4) idle();

    // Single-cycle valid pulse between idle cycles.
    step(1'b1, 10'd500, 10'd0, 10'd5, 10'd5, 10'd452);
    repeat (5) idle();

    // Random mix of valid and idle cycles.
    for (int i = 0; i < 40; i++) begin
      int a, b, c, d;
      logic v;
      a = int'($urandom_range(1023));
      b = int'($urandom_range(1023));
      c = int'($urandom_range(1023));
      d = int'($urandom_range(1023));
      v = logic'($urandom_range(1));
      step(v, N'(a), N'(b), N'(c), N'(d), model(a, b, c, d));
    end

    // Asynchronous reset with valid data still in flight.
    step(1'b1, 10'd30, 10'd1, 10'd2, 10'd4, 10'd116);
    step(1'b1, 10'd10, 10'd10, 10'd30, 10'd1, 10'd49);
    step(1'b1, 10'd10, 10'd20, 10'd5, 10'd3, 10'd96);
    step(1'b1, 10'd20, 10'd11, 10'd1, 10'd4, 10'd112);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async F", bus.F, '0);
    chk("async out_valid", N'(bus.out_valid), '0);
    @(posedge clk);
    #1;
    chk("held F", bus.F, '0);
    chk("held out_valid", N'(bus.out_valid), '0);
    bus.in_valid = 1'b0;
    release_reset();

    for (int i = 0; i < 4; i++)
      step(1'b1, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].f);
    repeat (4) idle();

    $display("== %0d vectors applied, %0d miscompares ==", napplied, nmis);
    $finish;
  end

endmodule
